// File: rtl/rr_arbiter4_pkg.sv
// Shared types and the rotating priority search for the 4-way round-robin arbiter.
package rr_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } search_t;

  // Walks start, start+1, ... (mod 4); masked-out bits never win.
  // Scanning from the far end lets the nearest set bit overwrite the result last.
  function automatic search_t rr_search(input logic [NUM_REQ-1:0] req,
                                        input logic [IDX_W-1:0]   start,
                                        input logic [NUM_REQ-1:0] excl);
    search_t              res;
    logic [NUM_REQ-1:0]   cand;
    logic [IDX_W-1:0]     k;
    res.found = 1'b0;
    res.idx   = '0;
    cand      = req & ~excl;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = start + i[IDX_W-1:0];
      if (cand[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/Decoder2to4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module Decoder2to4 (
  input  logic [1:0] I,
  input  logic       E,
  output logic [3:0] Y
);

  assign Y = E ? (4'b0001 << I) : 4'b0000;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with per-grant hold limit; all outputs registered
// (gnt is a pure decode of the registered grant index and valid).
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout,
  output logic       o_dbg_state
);

  localparam int             CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gnt_id;
  logic             r_gnt_valid;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;

  search_t          w_first;
  search_t          w_next;
  logic             w_hold_req;
  logic             w_handoff;

  assign w_first    = rr_search(req, r_ptr, 4'b0000);
  // Successor search skips the current holder so a timeout really moves on.
  assign w_next     = rr_search(req, r_gnt_id + 2'd1, 4'b0001 << r_gnt_id);
  assign w_hold_req = req[r_gnt_id];
  assign w_handoff  = !w_hold_req || (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en && w_first.found) begin
            r_state     <= GRANT;
            r_gnt_id    <= w_first.idx;
            r_gnt_valid <= 1'b1;
            r_cnt       <= '0;
          end
        end
        GRANT: begin
          if (w_handoff) begin
            r_ptr     <= r_gnt_id + 2'd1;
            r_timeout <= w_hold_req;
            r_cnt     <= '0;
            // A timed-out lone requester is simply re-granted in place.
            if (en && (w_next.found || w_hold_req)) begin
              if (w_next.found) r_gnt_id <= w_next.idx;
            end else begin
              r_state     <= IDLE;
              r_gnt_valid <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  Decoder2to4 u_dec (
    .I (r_gnt_id),
    .E (r_gnt_valid),
    .Y (gnt)
  );

  assign gnt_id      = r_gnt_id;
  assign gnt_valid   = r_gnt_valid;
  assign timeout     = r_timeout;
  assign o_dbg_state = (r_state == GRANT);

endmodule

// File: tb/tb_rr_arbiter4.sv
// Randomized scoreboard bench for rr_arbiter4: two instances (MAX_HOLD=4 and 1)
// share stimulus and are each compared against a behavioural ownership model.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;

  logic [3:0] g0, g1;
  logic [1:0] id0, id1;
  logic       v0, v1, t0, t1, s0, s1;

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];

  int n_checks;
  int n_err;

  // Model: who holds the resource, for how many cycles so far, and who is next in line.
  bit m_hold[2];
  int m_holder[2];
  int m_ptr[2];
  int m_held[2];
  int m_max[2];

  rr_arbiter4 #(.MAX_HOLD(4)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(g0), .gnt_id(id0), .gnt_valid(v0), .timeout(t0), .o_dbg_state(s0)
  );

  rr_arbiter4 #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(g1), .gnt_id(id1), .gnt_valid(v1), .timeout(t1), .o_dbg_state(s1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] pack(input logic s, input logic t, input logic v,
                                      input logic [3:0] g, input logic [1:0] id);
    return {s, t, v, g, (v ? id : 2'b00)};
  endfunction

  // First requester in round-robin order from 'start', ignoring client 'excl'; -1 if none.
  function automatic int pick(input logic [3:0] r, input int start, input int excl);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (start + k) % 4;
      if (idx != excl && r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input logic r, input logic e,
                            input logic [3:0] q, output logic [8:0] x);
    int w;
    logic tmo;
    logic [3:0] g;
    tmo = 1'b0;
    if (r) begin
      m_hold[d] = 0; m_ptr[d] = 0; m_held[d] = 0; m_holder[d] = 0;
    end else if (!m_hold[d]) begin
      if (e) begin
        w = pick(q, m_ptr[d], -1);
        if (w >= 0) begin
          m_hold[d] = 1; m_holder[d] = w; m_held[d] = 1;
        end
      end
    end else if (!q[m_holder[d]]) begin
      m_ptr[d] = (m_holder[d] + 1) % 4;
      w = pick(q, m_ptr[d], -1);
      if (e && w >= 0) begin
        m_holder[d] = w; m_held[d] = 1;
      end else begin
        m_hold[d] = 0;
      end
    end else if (m_held[d] == m_max[d]) begin
      tmo = 1'b1;
      m_ptr[d] = (m_holder[d] + 1) % 4;
      if (e) begin
        w = pick(q, m_ptr[d], m_holder[d]);
        if (w >= 0) m_holder[d] = w;
        m_held[d] = 1;
      end else begin
        m_hold[d] = 0;
      end
    end else begin
      m_held[d]++;
    end
    g = m_hold[d] ? (4'b0001 << m_holder[d]) : 4'b0000;
    x = pack(m_hold[d], tmo, m_hold[d], g, 2'(m_holder[d]));
  endtask

  // driver: apply one cycle of inputs and queue what each instance must show after the edge
  task automatic drive(input logic r, input logic e, input logic [3:0] q);
    logic [8:0] x;
    @(negedge clk);
    rst = r;
    en  = e;
    req = q;
    model_step(0, r, e, q, x);
    exp_q0.push_back(x);
    model_step(1, r, e, q, x);
    exp_q1.push_back(x);
  endtask

  task automatic drive_n(input int n, input logic r, input logic e, input logic [3:0] q);
    for (int i = 0; i < n; i++) drive(r, e, q);
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [8:0] e_val;
    logic [8:0] a_val;
    #1;
    if (exp_q0.size() > 0) begin
      e_val = exp_q0.pop_front();
      a_val = pack(s0, t0, v0, g0, id0);
      n_checks++;
      if (a_val !== e_val) begin
        n_err++;
        $display("FAIL arb_mh4 t=%0t {state,timeout,valid,gnt,id} got %b expected %b",
                 $time, a_val, e_val);
      end
    end
    if (exp_q1.size() > 0) begin
      e_val = exp_q1.pop_front();
      a_val = pack(s1, t1, v1, g1, id1);
      n_checks++;
      if (a_val !== e_val) begin
        n_err++;
        $display("FAIL arb_mh1 t=%0t {state,timeout,valid,gnt,id} got %b expected %b",
                 $time, a_val, e_val);
      end
    end
  end

  initial begin
    logic [3:0] cur_req;
    logic       cur_en;
    n_checks = 0;
    n_err    = 0;
    m_max[0] = 4;
    m_max[1] = 1;
    for (int d = 0; d < 2; d++) begin
      m_hold[d] = 0; m_holder[d] = 0; m_ptr[d] = 0; m_held[d] = 0;
    end
    rst = 1'b1;
    en  = 1'b1;
    req = 4'b1111;

    // reset with everyone requesting, then full rotation
    drive_n(2, 1'b1, 1'b1, 4'b1111);
    drive_n(18, 1'b0, 1'b1, 4'b1111);
    // bring client 2 in, then release handoff to client 3
    drive_n(2, 1'b0, 1'b1, 4'b0100);
    drive_n(2, 1'b0, 1'b1, 4'b1001);
    // lone holder repeatedly timing out
    drive_n(12, 1'b0, 1'b1, 4'b0010);
    // enable gating in idle and mid-grant
    drive_n(2, 1'b0, 1'b0, 4'b0000);
    drive_n(3, 1'b0, 1'b0, 4'b0100);
    drive_n(3, 1'b0, 1'b1, 4'b0100);
    drive_n(2, 1'b0, 1'b0, 4'b0100);
    drive_n(2, 1'b0, 1'b0, 4'b0000);
    // mid-grant reset with client 3 still requesting
    drive_n(6, 1'b0, 1'b1, 4'b1000);
    drive_n(1, 1'b1, 1'b1, 4'b1000);
    drive_n(3, 1'b0, 1'b1, 4'b1000);

    // random traffic with sticky requests so holders run into the hold limit
    cur_req = 4'b0000;
    cur_en  = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) cur_req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) cur_en = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 99) == 0), cur_en, cur_req);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_err++;
      $display("FAIL drain queued got %0d/%0d expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter for a single shared resource. It owns the grant index for the resource and drives a one-hot grant vector through a 2-to-4 decoder, with the decoder's enable used as grant-valid. A per-grant hold counter bounds how long any one requester keeps the resource. It sits between four client blocks and the shared resource's select/enable inputs.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles one requester may hold a grant; legal range 1..255.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  arbitration enable. 0 blocks new grants; the current grant continues until release or timeout.
- req  input  4  request per client; bit i belongs to client i. Held high for as long as the client wants the resource.
- gnt  output  4  one-hot grant; all zero when no grant is active.
- gnt_id  output  2  index of the current holder; meaningful only while gnt_valid=1.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a holder is preempted at MAX_HOLD.

## Operation
- State machine has two states:
  - IDLE: no grant.
  - GRANT: a holder owns the resource.
- Reset values: state=IDLE, gnt=0000, gnt_id=00, gnt_valid=0, timeout=0, ptr=00, hold count=0.
- ptr is the highest-priority index. The search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4; the first set request in that order wins.
- IDLE:
  - If en=1 and req≠0: winner → gnt_id, gnt_valid=1, cnt=0, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, release (req[gnt_id]=0):
  - ptr ← gnt_id+1.
  - If en=1 and another request is set, grant it on the same edge, searching from gnt_id+1, with cnt=0. There is no idle cycle between holders.
  - Otherwise go to IDLE with gnt_valid=0.
- GRANT, timeout (req[gnt_id]=1 and cnt=MAX_HOLD-1):
  - Pulse timeout=1 for one cycle and set ptr ← gnt_id+1.
  - The search from gnt_id+1 excludes the current holder.
  - If another request is set and en=1, grant it.
  - If no other request is set and en=1, re-grant the same holder with cnt=0.
  - If en=0, go to IDLE.
- GRANT, otherwise: cnt ← cnt+1 and the grant is unchanged.
- cnt width is clog2(MAX_HOLD+1). cnt never exceeds MAX_HOLD-1, so it never wraps.
- ptr wraps from 3 to 0 by natural 2-bit overflow.
- gnt = decode(gnt_id) gated by gnt_valid, so gnt always equals 1<<gnt_id or 0000.
- en falling while a grant is active has no effect until that grant ends.
- rst asserted mid-grant: on that edge all outputs and state return to their reset values, regardless of req.

## Timing
- Grant latency: req sampled high at edge N produces gnt visible after edge N (one cycle), provided the arbiter is in IDLE and en=1.
- A holder owns the resource for at most MAX_HOLD consecutive cycles before a forced handoff.
- Release handoff: req[gnt_id] low at edge N means the next holder's gnt is visible after edge N.
- timeout is high in exactly the cycle after the preempting edge, coincident with the new gnt.
- All outputs are registered, with no combinational path from req to gnt.
- MAX_HOLD=1 is a legal configuration: every cycle is a preemption point, so the grant rotates each cycle while multiple clients request.

## Structure
- Shared package contents:
  - State enum {IDLE, GRANT}.
  - NUM_REQ=4 and IDX_W=2.
  - The rotate-and-priority-search function: takes the 4-bit req, the start index and an exclude mask; returns the found flag and the index.
- Sub-module: the existing Decoder2to4, with I=gnt_id, E=gnt_valid, Y=gnt.
- The top level holds the state register, ptr, cnt and the output registers.

## Test plan
- Reset: rst=1 with req=1111 → after the edge, gnt=0000, gnt_valid=0, timeout=0; the first grant after rst=0 goes to client 0.
- Rotation: req=1111 held, MAX_HOLD=8 → gnt_id sequence 0,1,2,3,0, each held 8 cycles, with timeout pulsing at each handoff.
- Release handoff: client 2 holds; req drops to 1001 → next cycle gnt=1000 (client 3), with no gap cycle and timeout=0.
- Lone holder timeout: req=0010 held, MAX_HOLD=4 → client 1 is re-granted every 4 cycles, timeout pulses every 4th cycle, and gnt stays 0010 continuously.
- Enable gating:
  - en=0 with req=0100 in IDLE → gnt stays 0000; en→1 → gnt=0100 one cycle later.
  - en→0 mid-grant → the grant persists until release.
- Mid-grant reset: client 3 holds with cnt=5; rst=1 for one edge → all outputs 0 and ptr=0; with req=1000 still high, the re-grant to client 3 appears one cycle after rst drops.
